// File: rtl/fir_pkg.sv
// Types and constants shared by the FIR output path.
// The FIR output stage imports this package.
package fir_pkg;

    localparam int FIR_DATA_WIDTH = 24;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } ser_state_t;

endpackage

// File: rtl/fir_word_fifo.sv
// Small synchronous FIFO that holds parallel FIR words ahead of the serializer.
// Full and empty are derived from a level counter, which keeps them free of pointer-compare ambiguity.
module fir_word_fifo
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_en,
    input  logic                        i_push,
    input  logic                        i_pop,
    input  logic [DATA_WIDTH-1:0]       i_data,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_level
);

    localparam int ADDR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wr_ptr_r;
    logic [ADDR_W-1:0]     rd_ptr_r;
    logic [LVL_W-1:0]      level_r;
    logic                  do_push_s;
    logic                  do_pop_s;

    assign o_full    = (level_r == LVL_W'(FIFO_DEPTH));
    assign o_empty   = (level_r == LVL_W'(0));
    assign o_level   = level_r;
    assign o_data    = mem_r[rd_ptr_r];
    assign do_push_s = i_rst_n & i_en & i_push & ~o_full;
    assign do_pop_s  = i_rst_n & i_en & i_pop & ~o_empty;

    // Word storage, written only on an accepted push.
    always_ff @(posedge i_clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_r <= ADDR_W'(0);
            rd_ptr_r <= ADDR_W'(0);
            level_r  <= LVL_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + ADDR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + ADDR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LVL_W'(1);
                2'b01:   level_r <= level_r - LVL_W'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/fir_out_serializer.sv
// FIR output stage: buffers parallel result words and shifts each one out LSB first.
// o_dout_valid frames each word and drops for at least GAP_CYCLES between words.
module fir_out_serializer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = FIR_DATA_WIDTH,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_word_valid,
    output logic                  o_word_ready,
    input  logic                  i_ready,
    output logic                  o_dout,
    output logic                  o_dout_valid
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    ser_state_t            state_r, state_s;
    logic [DATA_WIDTH-1:0] sr_r, sr_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [GAP_W-1:0]      gap_cnt_r, gap_cnt_s;
    logic                  dout_r, dout_s;
    logic                  dout_valid_r, dout_valid_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic [DATA_WIDTH-1:0] fifo_head_s;
    logic [$clog2(FIFO_DEPTH):0] unused_level_s;

    // Readiness uses the registered full flag, so a same-cycle pop never frees a slot early.
    assign o_word_ready = i_rst_n & i_en & ~fifo_full_s;
    assign push_s       = i_word_valid & o_word_ready;
    assign o_dout       = dout_r;
    assign o_dout_valid = dout_valid_r;

    fir_word_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_en),
        .i_push  (push_s),
        .i_pop   (pop_s),
        .i_data  (i_word),
        .o_data  (fifo_head_s),
        .o_full  (fifo_full_s),
        .o_empty (fifo_empty_s),
        .o_level (unused_level_s)
    );

    // Next-state and next-output logic; everything holds while i_en is low.
    always_comb begin
        state_s      = state_r;
        sr_s         = sr_r;
        cnt_s        = cnt_r;
        gap_cnt_s    = gap_cnt_r;
        dout_s       = dout_r;
        dout_valid_s = dout_valid_r;
        pop_s        = 1'b0;
        if (i_en) begin
            case (state_r)
                S_IDLE: begin
                    if (!fifo_empty_s) begin
                        pop_s        = 1'b1;
                        sr_s         = fifo_head_s;
                        cnt_s        = CNT_W'(0);
                        dout_s       = fifo_head_s[0];
                        dout_valid_s = 1'b1;
                        state_s      = S_SHIFT;
                    end else begin
                        dout_s       = 1'b0;
                        dout_valid_s = 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (i_ready && (cnt_r == CNT_LAST)) begin
                        gap_cnt_s    = GAP_W'(0);
                        dout_s       = 1'b0;
                        dout_valid_s = 1'b0;
                        state_s      = S_GAP;
                    end else if (i_ready) begin
                        sr_s         = {1'b0, sr_r[DATA_WIDTH-1:1]};
                        cnt_s        = cnt_r + CNT_W'(1);
                        dout_s       = sr_r[1];
                        dout_valid_s = 1'b1;
                    end else begin
                        dout_s       = sr_r[0];
                        dout_valid_s = 1'b1;
                    end
                end
                S_GAP: begin
                    dout_s       = 1'b0;
                    dout_valid_s = 1'b0;
                    if (gap_cnt_r == GAP_LAST) begin
                        state_s = S_IDLE;
                    end else begin
                        gap_cnt_s = gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    dout_s       = 1'b0;
                    dout_valid_s = 1'b0;
                    state_s      = S_IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, datapath and output registers; reset discards any partial word.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r      <= S_IDLE;
            sr_r         <= DATA_WIDTH'(0);
            cnt_r        <= CNT_W'(0);
            gap_cnt_r    <= GAP_W'(0);
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            sr_r         <= sr_s;
            cnt_r        <= cnt_s;
            gap_cnt_r    <= gap_cnt_s;
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
        end
    end

endmodule

// File: tb/tb_fir_out_serializer.sv
// Directed bench for fir_out_serializer: a small sink model reassembles the serial
// stream and compares it against hand-chosen words, framing and freeze behaviour.
module tb_fir_out_serializer;
    import fir_pkg::*;

    localparam int GAP_CYCLES = 1;

    logic        tb_clk;
    logic        i_rst_n;
    logic        i_en;
    logic [23:0] i_word;
    logic        i_word_valid;
    logic        o_word_ready;
    logic        i_ready;
    logic        o_dout;
    logic        o_dout_valid;

    int check_cnt = 0;
    int err_cnt   = 0;

    logic [23:0] exp_q [$];
    logic [23:0] got_q [$];
    logic [23:0] acc_w;
    int          nbits;
    int          rises;
    int          gap_len;
    logic        prev_valid;

    fir_out_serializer #(
        .DATA_WIDTH (24),
        .FIFO_DEPTH (4),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .i_clk        (tb_clk),
        .i_rst_n      (i_rst_n),
        .i_en         (i_en),
        .i_word       (i_word),
        .i_word_valid (i_word_valid),
        .o_word_ready (o_word_ready),
        .i_ready      (i_ready),
        .o_dout       (o_dout),
        .o_dout_valid (o_dout_valid)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic sink_reset();
        got_q.delete();
        exp_q.delete();
        acc_w      = 24'h0;
        nbits      = 0;
        rises      = 0;
        gap_len    = 0;
        prev_valid = 1'b0;
    endtask

    // Sink model: drives i_ready/i_en, accepts a pending push, reassembles words.
    task automatic run_sink(input int cycles, input int toggle_ready, input int en_off_at);
        logic pushed;
        for (int c = 0; c < cycles; c++) begin
            i_ready = (toggle_ready == 0) ? 1'b1 : ((c % 2) == 0);
            i_en    = !((en_off_at >= 0) && (c >= en_off_at) && (c < en_off_at + 7));
            #1;
            if (!i_en) begin
                check("en_off_ready", 32'(o_word_ready), 32'd0);
                check("en_off_cnt", 32'(dut.cnt_r), 32'(nbits));
            end
            if (o_dout_valid) begin
                if (!prev_valid) begin
                    rises++;
                    if (got_q.size() > 0) begin
                        check("gap_len_min", 32'(gap_len >= GAP_CYCLES), 32'd1);
                    end
                end
                if (got_q.size() < exp_q.size()) begin
                    check("bit", 32'(o_dout), 32'(exp_q[got_q.size()][nbits]));
                end else begin
                    check("extra_word", 32'(o_dout_valid), 32'd0);
                end
                if (i_ready && i_en) begin
                    acc_w[nbits] = o_dout;
                    nbits++;
                    if (nbits == 24) begin
                        got_q.push_back(acc_w);
                        nbits = 0;
                        acc_w = 24'h0;
                    end
                end
                gap_len = 0;
            end else begin
                check("dout_idle_zero", 32'(o_dout), 32'd0);
                if (nbits != 0) begin
                    check("word_cut_short", 32'(nbits), 32'd0);
                end
                gap_len++;
            end
            pushed     = i_word_valid & o_word_ready;
            prev_valid = o_dout_valid;
            tick();
            if (pushed) begin
                i_word_valid = 1'b0;
            end
        end
        i_en = 1'b1;
    endtask

    task automatic sink_finish(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        check({tag, "_rises"}, 32'(rises), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [23:0] t2_word;
        int          idx;
        logic        acc;

        // Test 1: reset held with a word offered
        i_rst_n      = 1'b0;
        i_en         = 1'b1;
        i_word       = 24'h123456;
        i_word_valid = 1'b1;
        i_ready      = 1'b0;
        repeat (5) tick();
        check("rst_valid", 32'(o_dout_valid), 32'd0);
        check("rst_dout", 32'(o_dout), 32'd0);
        check("rst_word_ready", 32'(o_word_ready), 32'd0);
        check("rst_level", 32'(dut.u_fifo.o_level), 32'd0);
        check("rst_state", 32'(dut.state_r), 32'(S_IDLE));
        i_rst_n      = 1'b1;
        i_word_valid = 1'b0;
        tick();

        // Test 2: latency and LSB-first bit order with i_ready held high
        t2_word      = 24'hA5C3F0;
        i_word       = t2_word;
        i_word_valid = 1'b1;
        i_ready      = 1'b1;
        #1;
        check("t2_ready", 32'(o_word_ready), 32'd1);
        tick();
        i_word_valid = 1'b0;
        check("t2_valid_at_push", 32'(o_dout_valid), 32'd0);
        tick();
        for (int k = 0; k < 24; k++) begin
            check("t2_valid", 32'(o_dout_valid), 32'd1);
            check("t2_bit", 32'(o_dout), 32'(t2_word[k]));
            tick();
        end
        check("t2_valid_fall", 32'(o_dout_valid), 32'd0);
        check("t2_dout_fall", 32'(o_dout), 32'd0);
        for (int k = 0; k < GAP_CYCLES + 2; k++) begin
            tick();
            check("t2_valid_stays_low", 32'(o_dout_valid), 32'd0);
        end

        // Test 3: toggling i_ready, output must hold while the sink stalls
        sink_reset();
        exp_q.push_back(24'h800001);
        i_word       = 24'h800001;
        i_word_valid = 1'b1;
        run_sink(70, 1, -1);
        sink_finish("t3");

        // Test 4: fill FIFO plus shift register with the sink stalled
        i_ready = 1'b0;
        idx     = 1;
        for (int c = 0; c < 8; c++) begin
            i_word       = 24'(idx);
            i_word_valid = 1'b1;
            #1;
            acc = o_word_ready;
            tick();
            if (acc) begin
                idx++;
            end
        end
        check("t4_accepted", 32'(idx - 1), 32'd5);
        check("t4_ready_full", 32'(o_word_ready), 32'd0);
        check("t4_level_full", 32'(dut.u_fifo.o_level), 32'd4);
        sink_reset();
        for (int w = 1; w <= 6; w++) begin
            exp_q.push_back(24'(w));
        end
        run_sink(220, 0, -1);
        sink_finish("t4");

        // Test 5: reset mid-word discards it, next word starts clean
        i_ready      = 1'b1;
        i_word       = 24'hFFF000;
        i_word_valid = 1'b1;
        tick();
        i_word_valid = 1'b0;
        tick();
        repeat (10) tick();
        check("t5_mid_valid", 32'(o_dout_valid), 32'd1);
        check("t5_mid_bit10", 32'(o_dout), 32'd0);
        i_rst_n = 1'b0;
        tick();
        check("t5_rst_valid", 32'(o_dout_valid), 32'd0);
        check("t5_rst_dout", 32'(o_dout), 32'd0);
        check("t5_rst_level", 32'(dut.u_fifo.o_level), 32'd0);
        check("t5_rst_ready", 32'(o_word_ready), 32'd0);
        i_rst_n      = 1'b1;
        i_word       = 24'h00000F;
        i_word_valid = 1'b1;
        #1;
        check("t5_ready_after", 32'(o_word_ready), 32'd1);
        tick();
        i_word_valid = 1'b0;
        tick();
        check("t5_first_valid", 32'(o_dout_valid), 32'd1);
        check("t5_first_bit", 32'(o_dout), 32'd1);
        sink_reset();
        exp_q.push_back(24'h00000F);
        run_sink(40, 0, -1);
        sink_finish("t5");

        // Test 6: enable dropped for 7 cycles mid-word
        sink_reset();
        exp_q.push_back(24'h5A3C96);
        i_word       = 24'h5A3C96;
        i_word_valid = 1'b1;
        run_sink(70, 0, 8);
        sink_finish("t6");

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
        $finish;
    end

endmodule
